// File: rtl/dram_read_assembler_if.sv
// Bus bundle between the scratchpad backend, the DRAM read channel and the
// scratchpad SRAM write port for dram_read_assembler.
//   rd_req_*    : row read request (backend -> assembler)
//   dram_rd_*   : beat read requests (assembler -> DRAM)
//   dram_resp_* : read response beats (DRAM -> assembler), always accepted
//   sram_wr_*   : assembled row with element mask (assembler -> SRAM)
//   busy        : assembler not idle
//   err_dup     : sticky protocol error (only with DRAM_RD_DUP_CHECK_EN)
// Modport slave is the assembler side; master is the environment side.
interface dram_read_assembler_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ELEM_W    = 16,
  parameter int unsigned ROW_ELEMS = 32,
  parameter int unsigned BEAT_W    = 64
);
  logic                        rd_req_valid;
  logic                        rd_req_ready;
  logic [ADDR_W-1:0]           rd_req_addr;
  logic [3:0]                  rd_req_num_beats;
  logic [ROW_ELEMS-1:0]        rd_req_mask;
  logic                        dram_rd_valid;
  logic                        dram_rd_ready;
  logic [ADDR_W-1:0]           dram_rd_addr;
  logic                        dram_resp_valid;
  logic [2:0]                  dram_resp_beat;
  logic [BEAT_W-1:0]           dram_resp_data;
  logic                        sram_wr_valid;
  logic                        sram_wr_ready;
  logic [ROW_ELEMS*ELEM_W-1:0] sram_wr_data;
  logic [ROW_ELEMS-1:0]        sram_wr_mask;
  logic                        busy;
  logic                        err_dup;

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_num_beats, rd_req_mask,
    input  dram_rd_ready, dram_resp_valid, dram_resp_beat, dram_resp_data,
    input  sram_wr_ready,
    output rd_req_ready, dram_rd_valid, dram_rd_addr,
    output sram_wr_valid, sram_wr_data, sram_wr_mask, busy, err_dup
  );

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_num_beats, rd_req_mask,
    output dram_rd_ready, dram_resp_valid, dram_resp_beat, dram_resp_data,
    output sram_wr_ready,
    input  rd_req_ready, dram_rd_valid, dram_rd_addr,
    input  sram_wr_valid, sram_wr_data, sram_wr_mask, busy, err_dup
  );
endinterface

// File: rtl/dram_read_assembler.sv
// Fetches one scratchpad row from DRAM as up to 8 x 64-bit beats, assembles the
// (possibly out-of-order) response beats into a 32 x 16-bit row and hands the
// row plus element mask to the SRAM write port.
// Ports:
//   clk   : clock
//   n_rst : asynchronous active-low reset
//   bus   : dram_read_assembler_if.slave (request, DRAM read, SRAM write, status)
// Optional feature macro DRAM_RD_DUP_CHECK_EN: flag (sticky err_dup) and drop
// duplicate, out-of-range and out-of-state responses instead of accepting them.
module dram_read_assembler #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ELEM_W    = 16,
  parameter int unsigned ROW_ELEMS = 32,
  parameter int unsigned BEAT_W    = 64
) (
  input logic                  clk,
  input logic                  n_rst,
  dram_read_assembler_if.slave bus
);
  localparam int unsigned ElemsPerBeat = BEAT_W / ELEM_W;
  localparam int unsigned MAX_BEATS    = ROW_ELEMS / ElemsPerBeat;
  localparam int unsigned RowW         = ROW_ELEMS * ELEM_W;

  typedef enum logic [1:0] {StIdle, StActive, StWrite} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-7:0]      base_q, base_d;
  logic [3:0]             num_q, num_d;
  logic [3:0]             issue_cnt_q, issue_cnt_d;
  logic [MAX_BEATS-1:0]   got_q, got_d;
  logic [ROW_ELEMS-1:0]   mask_q, mask_d;
  logic [RowW-1:0]        row_q, row_d;
  logic                   err_q, err_d;

  logic [3:0]             req_num;
  logic [ROW_ELEMS-1:0]   req_cov;
  logic [MAX_BEATS-1:0]   need;
  logic [MAX_BEATS-1:0]   resp_bit;
  logic                   resp_hit, resp_dup, resp_wr;
  logic                   rd_valid, rd_fire;
  logic                   unused_addr_lsbs;

  // Row-aligned base: the low byte-address bits select nothing within a row.
  assign unused_addr_lsbs = ^bus.rd_req_addr[5:0];

  always_comb begin
    req_num = bus.rd_req_num_beats;
    if (bus.rd_req_num_beats == 4'd0 || bus.rd_req_num_beats > 4'(MAX_BEATS)) begin
      req_num = 4'(MAX_BEATS);
    end
    for (int unsigned e = 0; e < ROW_ELEMS; e++) begin
      req_cov[e] = (e < ElemsPerBeat * 32'(req_num));
    end
    for (int unsigned b = 0; b < MAX_BEATS; b++) begin
      need[b] = (b < 32'(num_q));
    end
  end

  assign rd_valid = (state_q == StActive) && (issue_cnt_q < num_q);
  assign rd_fire  = rd_valid && bus.dram_rd_ready;
  assign resp_bit = MAX_BEATS'(1) << bus.dram_resp_beat;
  assign resp_hit = bus.dram_resp_valid && (state_q == StActive) &&
                    ({1'b0, bus.dram_resp_beat} < num_q);
  assign resp_dup = resp_hit && got_q[bus.dram_resp_beat];

`ifdef DRAM_RD_DUP_CHECK_EN
  assign resp_wr = resp_hit && !resp_dup;
  assign err_d   = err_q || (bus.dram_resp_valid && !resp_wr);
`else
  assign resp_wr = resp_hit;
  assign err_d   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    issue_cnt_d = issue_cnt_q;
    got_d       = got_q;
    mask_d      = mask_q;
    row_d       = row_q;
    case (state_q)
      StIdle: begin
        if (bus.rd_req_valid) begin
          base_d      = bus.rd_req_addr[ADDR_W-1:6];
          num_d       = req_num;
          mask_d      = bus.rd_req_mask & req_cov;
          row_d       = '0;
          issue_cnt_d = '0;
          got_d       = '0;
          state_d     = StActive;
        end
      end
      StActive: begin
        if (rd_fire) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (resp_wr) begin
          row_d[32'(bus.dram_resp_beat) * BEAT_W +: BEAT_W] = bus.dram_resp_data;
        end
        if (resp_hit) begin
          got_d = got_q | resp_bit;
          // Includes the incoming beat so the row is presented one cycle later.
          if ((got_d & need) == need) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (bus.sram_wr_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      num_q       <= '0;
      issue_cnt_q <= '0;
      got_q       <= '0;
      mask_q      <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issue_cnt_q <= issue_cnt_d;
      got_q       <= got_d;
      mask_q      <= mask_d;
      row_q       <= row_d;
      err_q       <= err_d;
    end
  end

  assign bus.rd_req_ready  = (state_q == StIdle);
  assign bus.busy          = (state_q != StIdle);
  assign bus.dram_rd_valid = rd_valid;
  assign bus.dram_rd_addr  = {base_q, issue_cnt_q[2:0], 3'b000};
  assign bus.sram_wr_valid = (state_q == StWrite);
  assign bus.sram_wr_data  = row_q;
  assign bus.sram_wr_mask  = mask_q;
  assign bus.err_dup       = err_q;

endmodule

// File: tb/tb_dram_read_assembler.sv
// Randomized bench for dram_read_assembler: a DRAM responder returns issued
// beats in random order, and a transaction-level model (row as an array of
// beats plus a received set) predicts every output on every cycle.
module tb_dram_read_assembler;
`ifdef DRAM_RD_DUP_CHECK_EN
  localparam bit DupChk = 1'b1;
`else
  localparam bit DupChk = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  dram_read_assembler_if bus ();
  dram_read_assembler dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MIdle, MActive, MWrite} mphase_e;
  mphase_e     ph = MIdle;
  int          m_n = 0, issued = 0, acc_cnt = 0, done_cnt = 0, acc_cyc = 0, hs_cyc = 0;
  logic [31:0] m_base = '0, m_mask = '0, last_issue_addr = '0;
  logic [7:0]  got = '0;
  logic [63:0] m_row [8];
  logic        err_exp = 1'b0;
  logic [511:0] last_row = '0;

  function automatic logic [511:0] exp_row();
    logic [511:0] r = '0;
    for (int e = 0; e < 32; e++) begin
      if (e < 4 * m_n) r[16*e +: 16] = m_row[e/4][16*(e%4) +: 16];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    for (int e = 0; e < 32; e++) m[e] = m_mask[e] && (e < 4 * m_n);
    return m;
  endfunction

  always @(negedge clk) begin
    mphase_e cur;
    int      nr;
    int      b;
    if (!n_rst) begin
      ph = MIdle; got = '0; issued = 0; err_exp = 1'b0; m_n = 0;
      chk("rst_rd_req_ready", bus.rd_req_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_dram_rd_valid", bus.dram_rd_valid, 0);
      chk("rst_dram_rd_addr", bus.dram_rd_addr, 0);
      chk("rst_sram_wr_valid", bus.sram_wr_valid, 0);
      chk("rst_sram_wr_data", bus.sram_wr_data, 0);
      chk("rst_sram_wr_mask", bus.sram_wr_mask, 0);
      chk("rst_err_dup", bus.err_dup, 0);
    end else begin
      cur = ph;
      chk("err_dup", bus.err_dup, err_exp);
      chk("rd_req_ready", bus.rd_req_ready, cur == MIdle);
      chk("busy", bus.busy, cur != MIdle);
      chk("sram_wr_valid", bus.sram_wr_valid, cur == MWrite);
      chk("dram_rd_valid", bus.dram_rd_valid, cur == MActive && issued < m_n);
      if (cur == MActive && issued < m_n) begin
        chk("dram_rd_addr", bus.dram_rd_addr, m_base + 32'(8 * issued));
        if (bus.dram_rd_ready) begin
          last_issue_addr = m_base + 32'(8 * issued);
          issued++;
        end
      end
      if (cur == MWrite) begin
        chk("sram_wr_data", bus.sram_wr_data, exp_row());
        chk("sram_wr_mask", bus.sram_wr_mask, exp_mask());
        if (bus.sram_wr_ready) begin
          ph = MIdle; hs_cyc = cyc; done_cnt++; last_row = exp_row();
        end
      end
      if (cur == MIdle && bus.rd_req_valid) begin
        nr     = int'(bus.rd_req_num_beats);
        m_n    = (nr == 0 || nr > 8) ? 8 : nr;
        m_base = bus.rd_req_addr & ~32'h3f;
        m_mask = bus.rd_req_mask;
        issued = 0; got = '0;
        foreach (m_row[i]) m_row[i] = '0;
        ph = MActive; acc_cnt++; acc_cyc = cyc;
      end
      if (bus.dram_resp_valid) begin
        b = int'(bus.dram_resp_beat);
        if (cur == MActive && b < m_n) begin
          if (got[b] && DupChk) err_exp = 1'b1;
          else m_row[b] = bus.dram_resp_data;
          got[b] = 1'b1;
          if ($countones(got) == m_n) ph = MWrite;
        end else if (DupChk) begin
          err_exp = 1'b1;
        end
      end
    end
  end

  // ---------------- DRAM responder ----------------
  logic [2:0]  pend [$];
  logic [2:0]  inj_beat [$];
  logic [63:0] inj_data [$];
  int          inj_rd = 0;
  bit          resp_en = 1'b0, in_order = 1'b1, pat_mode = 1'b0;
  int          resp_pct = 100;

  initial begin
    int         idx;
    logic [2:0] rb;
    bus.dram_resp_valid = 1'b0;
    bus.dram_resp_beat  = '0;
    bus.dram_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (resp_en && n_rst && bus.dram_rd_valid && bus.dram_rd_ready)
        pend.push_back(bus.dram_rd_addr[5:3]);
      @(posedge clk);
      #1;
      bus.dram_resp_valid = 1'b0;
      if (inj_rd < inj_beat.size()) begin
        bus.dram_resp_valid = 1'b1;
        bus.dram_resp_beat  = inj_beat[inj_rd];
        bus.dram_resp_data  = inj_data[inj_rd];
        inj_rd++;
      end else if (resp_en && pend.size() > 0 && $urandom_range(99) < resp_pct) begin
        idx = in_order ? 0 : int'($urandom_range(pend.size() - 1));
        rb  = pend[idx];
        pend.delete(idx);
        bus.dram_resp_valid = 1'b1;
        bus.dram_resp_beat  = rb;
        bus.dram_resp_data  = pat_mode ? {4{16'(rb)}} : {$urandom, $urandom};
      end
    end
  end

  // ---------------- ready drivers ----------------
  int rdy_pct = 100, wr_pct = 100, stall_used = 0;
  bit stall_en = 1'b0;

  initial begin
    bus.dram_rd_ready = 1'b1;
    bus.sram_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_en) stall_used = 0;
      // Hold off the second beat request for 5 cycles.
      if (stall_en && issued == 1 && stall_used < 5) begin
        bus.dram_rd_ready = 1'b0;
        stall_used++;
      end else begin
        bus.dram_rd_ready = ($urandom_range(99) < rdy_pct);
      end
      bus.sram_wr_ready = ($urandom_range(99) < wr_pct);
    end
  end

  // ---------------- main sequence ----------------
  task automatic start_req(input logic [31:0] a, input logic [3:0] n, input logic [31:0] m);
    @(posedge clk);
    #1;
    bus.rd_req_valid     = 1'b1;
    bus.rd_req_addr      = a;
    bus.rd_req_num_beats = n;
    bus.rd_req_mask      = m;
  endtask

  task automatic wait_acc(input int prev);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (acc_cnt != prev) break;
    end
    if (acc_cnt == prev) fail_now("req_accept");
    #1 bus.rd_req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] n, input logic [31:0] m);
    int prev = acc_cnt;
    start_req(a, n, m);
    wait_acc(prev);
  endtask

  task automatic wait_write();
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (ph == MWrite) break;
    end
    if (ph != MWrite) fail_now("reach_write");
    #2;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      if (done_cnt >= target) break;
    end
    if (done_cnt < target) fail_now("row_done");
  endtask

  task automatic inject(input logic [2:0] b, input logic [63:0] d);
    inj_beat.push_back(b);
    inj_data.push_back(d);
  endtask

  initial begin
    logic [511:0] v;
    logic [63:0]  d0, d1, d2, d3, d0b;
    logic [31:0]  m4;
    int           stalls, prev, tgt;
    bus.rd_req_valid     = 1'b0;
    bus.rd_req_addr      = '0;
    bus.rd_req_num_beats = '0;
    bus.rd_req_mask      = '0;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // In-order full row with beat-index pattern data.
    pat_mode = 1'b1; in_order = 1'b1; resp_en = 1'b1;
    do_req(32'h1000_0040, 4'd8, 32'hFFFF_FFFF);
    chk("t1_first_valid", bus.dram_rd_valid, 1);
    chk("t1_first_addr", bus.dram_rd_addr, 32'h1000_0040);
    wait_write();
    v = '0;
    for (int e = 0; e < 32; e++) v[16*e +: 16] = 16'(e / 4);
    chk("t1_row", bus.sram_wr_data, v);
    chk("t1_mask", bus.sram_wr_mask, 32'hFFFF_FFFF);
    chk("t1_last_addr", last_issue_addr, 32'h1000_0078);
    wait_done(1);
    pat_mode = 1'b0;

    // N=3, responses 2,0,1.
    resp_en = 1'b0;
    do_req(32'h2000_0000, 4'd3, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    inject(3'd2, d2); inject(3'd0, d0); inject(3'd1, d1);
    wait_write();
    chk("t2_mask", bus.sram_wr_mask, 32'h0000_0FFF);
    chk("t2_row", bus.sram_wr_data, {320'b0, d2, d1, d0});
    wait_done(2);

    // DRAM backpressure on the second beat request.
    resp_en = 1'b1; in_order = 1'b0; stall_en = 1'b1; stalls = 0;
    do_req(32'h3000_0017, 4'd8, $urandom);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #2;
      if (!bus.dram_rd_ready) begin
        stalls++;
        chk("t3_hold_addr", bus.dram_rd_addr, 32'h3000_0008);
        chk("t3_hold_valid", bus.dram_rd_valid, 1);
        chk("t3_busy", bus.busy, 1);
      end
    end
    chk("t3_stall_cycles", stalls, 5);
    stall_en = 1'b0;
    wait_done(3);
    chk("t3_issue_total", issued, 8);

    // SRAM backpressure, then back-to-back request with one bubble.
    wr_pct = 0; m4 = $urandom;
    do_req(32'h4000_0100, 4'd5, m4);
    wait_write();
    for (int k = 0; k < 4; k++) begin
      chk("t4_mask_hold", bus.sram_wr_mask, m4 & 32'h000F_FFFF);
      chk("t4_req_ready", bus.rd_req_ready, 0);
      chk("t4_wr_valid", bus.sram_wr_valid, 1);
      @(posedge clk);
      #2;
    end
    prev = acc_cnt;
    start_req(32'h5000_0000, 4'd0, $urandom);
    wr_pct = 100;
    wait_acc(prev);
    chk("t4_bubble", acc_cyc - hs_cyc, 1);
    wait_done(5);

    // Response while idle, then duplicate and out-of-range beats with N=4.
    resp_en = 1'b0;
    inject(3'd3, {$urandom, $urandom});
    repeat (4) @(posedge clk);
    #2;
    chk("t5_idle_row", bus.sram_wr_data, last_row);
    chk("t5_idle_busy", bus.busy, 0);
    do_req(32'h6000_0000, 4'd4, 32'hFFFF_FFFF);
    repeat (6) @(posedge clk);
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d0b = {$urandom, $urandom};
    d2 = {$urandom, $urandom}; d3 = {$urandom, $urandom};
    inject(3'd0, d0); inject(3'd1, d1); inject(3'd0, d0b);
    inject(3'd5, {$urandom, $urandom}); inject(3'd2, d2); inject(3'd3, d3);
    wait_write();
    chk("t5_row", bus.sram_wr_data, {256'b0, d3, d2, d1, DupChk ? d0 : d0b});
    chk("t5_mask", bus.sram_wr_mask, 32'h0000_FFFF);
    chk("t5_err_dup", bus.err_dup, DupChk);
    wait_done(6);

    // Reset after three of eight beats; trailing responses must be dropped.
    resp_en = 1'b1; in_order = 1'b1;
    do_req(32'h7000_0000, 4'd8, 32'hFFFF_FFFF);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if ($countones(got) >= 3) break;
    end
    if ($countones(got) < 3) fail_now("t6_three_beats");
    #1 n_rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_rd_req_ready", bus.rd_req_ready, 1);
    chk("t6_busy", bus.busy, 0);
    chk("t6_dram_rd_valid", bus.dram_rd_valid, 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    for (int k = 0; k < 50 && pend.size() > 0; k++) @(posedge clk);
    if (pend.size() > 0) fail_now("t6_drain");
    repeat (3) @(posedge clk);
    #2;
    chk("t6_idle_busy", bus.busy, 0);
    chk("t6_err_dup", bus.err_dup, DupChk);
    in_order = 1'b0;
    do_req(32'h7000_0040, 4'd6, $urandom);
    wait_done(7);

    // Random traffic.
    for (int t = 0; t < 20; t++) begin
      rdy_pct  = int'($urandom_range(100, 30));
      wr_pct   = int'($urandom_range(100, 30));
      resp_pct = int'($urandom_range(100, 40));
      in_order = 1'($urandom_range(1));
      tgt      = done_cnt + 1;
      do_req($urandom, 4'($urandom_range(15)), $urandom);
      wait_done(tgt);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
